// File: rtl/pixel_filter_pkg.sv
// Shared types and default sizes for the VGA per-pixel point filter.
package pixel_filter_pkg;

  localparam int unsigned DEF_PIX_W    = 8;
  localparam int unsigned DEF_CHANNELS = 3;
  localparam int unsigned MODE_W       = 3;

  typedef enum logic [MODE_W-1:0] {
    PASS     = 3'd0,
    BRIGHTEN = 3'd1,
    DARKEN   = 3'd2,
    INVERT   = 3'd3,
    THRESH   = 3'd4
  } filt_mode_t;

endpackage

// File: rtl/pixel_filter_chan.sv
// Combinational point operation on one colour channel.
module pixel_filter_chan
  import pixel_filter_pkg::*;
#(
  parameter int unsigned PIX_W = DEF_PIX_W
) (
  input  logic [MODE_W-1:0] mode,
  input  logic [PIX_W-1:0]  amount,
  input  logic [PIX_W-1:0]  pix,
  output logic [PIX_W-1:0]  result_c
);

  logic [PIX_W:0] sum;
  logic [PIX_W:0] diff;

  // Extra MSB of sum/diff flags overflow/underflow for clamping.
  always_comb begin
    sum      = {1'b0, pix} + {1'b0, amount};
    diff     = {1'b0, pix} - {1'b0, amount};
    result_c = pix;
    case (mode)
      BRIGHTEN: result_c = sum[PIX_W]  ? '1 : sum[PIX_W-1:0];
      DARKEN:   result_c = diff[PIX_W] ? '0 : diff[PIX_W-1:0];
      INVERT:   result_c = ~pix;
      THRESH:   result_c = (pix >= amount) ? '1 : '0;
      default:  result_c = pix;
    endcase
  end

endmodule

// File: rtl/pixel_filter_pipe.sv
// Two-stage valid/ready point filter; config is latched at SOP and travels with each beat.
module pixel_filter_pipe
  import pixel_filter_pkg::*;
#(
  parameter int unsigned PIX_W      = DEF_PIX_W,
  parameter int unsigned CHANNELS   = DEF_CHANNELS,
  parameter int unsigned DEF_AMOUNT = 50
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [MODE_W-1:0]         cfg_mode,
  input  logic [PIX_W-1:0]          cfg_amount,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHANNELS*PIX_W-1:0] in_data,
  input  logic                      in_sop,
  input  logic                      in_eop,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHANNELS*PIX_W-1:0] out_data,
  output logic                      out_sop,
  output logic                      out_eop,
  output logic                      frame_active
);

  localparam int unsigned DATA_W = CHANNELS * PIX_W;

  logic [MODE_W-1:0] cur_mode;
  logic [PIX_W-1:0]  cur_amount;
  logic [MODE_W-1:0] eff_mode;
  logic [PIX_W-1:0]  eff_amount;

  logic              s1_valid;
  logic              s1_sop;
  logic              s1_eop;
  logic [DATA_W-1:0] s1_data;
  logic [MODE_W-1:0] s1_mode;
  logic [PIX_W-1:0]  s1_amount;
  logic [DATA_W-1:0] s2_next;

  logic s2_adv;
  logic in_fire;
  logic out_fire;

  // S2 moves when empty or drained; S1 moves whenever S2 does.
  assign s2_adv   = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_adv;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // An SOP beat uses its own cfg; everything else uses the latched copy.
  assign eff_mode   = in_sop ? cfg_mode   : cur_mode;
  assign eff_amount = in_sop ? cfg_amount : cur_amount;

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_mode   <= MODE_W'(PASS);
      cur_amount <= PIX_W'(DEF_AMOUNT);
    end else if (in_fire && in_sop) begin
      cur_mode   <= cfg_mode;
      cur_amount <= cfg_amount;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_sop    <= 1'b0;
      s1_eop    <= 1'b0;
      s1_data   <= '0;
      s1_mode   <= MODE_W'(PASS);
      s1_amount <= '0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
      end
      if (in_fire) begin
        s1_sop    <= in_sop;
        s1_eop    <= in_eop;
        s1_data   <= in_data;
        s1_mode   <= eff_mode;
        s1_amount <= eff_amount;
      end
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    pixel_filter_chan #(
      .PIX_W (PIX_W)
    ) u_chan (
      .mode     (s1_mode),
      .amount   (s1_amount),
      .pix      (s1_data[c*PIX_W +: PIX_W]),
      .result_c (s2_next[c*PIX_W +: PIX_W])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= s2_next;
        out_sop  <= s1_sop;
        out_eop  <= s1_eop;
      end
    end
  end

  // A new SOP at the input wins over an EOP leaving in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_active <= 1'b0;
    end else if (in_fire && in_sop) begin
      frame_active <= 1'b1;
    end else if (out_fire && out_eop) begin
      frame_active <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pixel_filter_pipe.sv
// Scoreboard bench for pixel_filter_pipe: directed frames, backpressure and mid-frame reset.
module tb_pixel_filter_pipe;
  import pixel_filter_pkg::*;

  localparam int unsigned PW = 8;
  localparam int unsigned CH = 3;
  localparam int unsigned DW = PW * CH;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    cfg_mode;
  logic [PW-1:0] cfg_amount;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_sop;
  logic          in_eop;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_sop;
  logic          out_eop;
  logic          frame_active;

  beat_t exp_q[$];
  int    pass_cnt = 0;
  int    chk_cnt  = 0;
  logic  held;
  beat_t held_b;
  beat_t got_b;
  beat_t exp_b;
  int    acc;
  bit    low_ok;

  pixel_filter_pipe #(
    .PIX_W      (PW),
    .CHANNELS   (CH),
    .DEF_AMOUNT (50)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cfg_mode     (cfg_mode),
    .cfg_amount   (cfg_amount),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_sop       (in_sop),
    .in_eop       (in_eop),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_sop      (out_sop),
    .out_eop      (out_eop),
    .frame_active (frame_active)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  function automatic logic [DW-1:0] px(input int c0, input int c1, input int c2);
    return {8'(c2), 8'(c1), 8'(c0)};
  endfunction

  function automatic logic [PW-1:0] sat_add(input int p, input int a);
    return (p + a > 255) ? 8'd255 : 8'(p + a);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    chk_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, req);
  endtask

  // Drive one beat from the negedge; push its expectation on the accepting edge.
  task automatic send(input logic [DW-1:0] d, input logic sop, input logic eop,
                      input logic [2:0] m, input logic [PW-1:0] a,
                      input logic [DW-1:0] exp, input bit gap);
    int waited;
    waited = 0;
    if (gap) repeat ($urandom_range(0, 2)) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_sop = sop; in_eop = eop;
    cfg_mode = m; cfg_amount = a;
    #1;
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!in_ready) begin
      chk_cnt++;
      $display("FAIL in_ready_timeout actual=0 required=1");
    end else begin
      exp_q.push_back({exp, sop, eop});
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Monitor: pop and compare on every output transfer; enforce hold during stalls.
  always @(negedge clk) begin
    #2;
    if (reset) begin
      held = 1'b0;
    end else begin
      got_b = {out_data, out_sop, out_eop};
      if (held) begin
        check("stall_valid_hold", 32'(out_valid), 32'd1);
        check("stall_beat_hold", 32'(got_b), 32'(held_b));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk_cnt++;
          $display("FAIL unexpected_output actual=%0h required=none", got_b);
        end else begin
          exp_b = exp_q.pop_front();
          check("out_beat", 32'(got_b), 32'(exp_b));
        end
        held = 1'b0;
      end else if (out_valid) begin
        held   = 1'b1;
        held_b = got_b;
      end else begin
        held = 1'b0;
      end
    end
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_sop = 1'b0; in_eop = 1'b0;
    cfg_mode = 3'd0; cfg_amount = '0; out_ready = 1'b1; held = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_sop_eop", 32'({out_sop, out_eop}), 32'd0);
    check("rst_frame_active", 32'(frame_active), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Brighten by 50, with latency probe on the first beat.
    send(px(10, 200, 255), 1'b1, 1'b0, 3'd1, 8'd50, px(60, 250, 255), 1'b0);
    check("lat_not_yet_valid", 32'(out_valid), 32'd0);
    check("sop_sets_frame_active", 32'(frame_active), 32'd1);
    send(px(0, 205, 206), 1'b0, 1'b0, 3'd0, 8'd0, px(50, 255, 255), 1'b0);
    check("lat_valid_after_2", 32'(out_valid), 32'd1);
    check("lat_first_data", 32'(out_data), 32'(px(60, 250, 255)));
    send(px(100, 100, 100), 1'b0, 1'b0, 3'd2, 8'd9, px(150, 150, 150), 1'b0);
    send(px(255, 0, 1), 1'b0, 1'b1, 3'd0, 8'd0, px(255, 50, 51), 1'b0);
    wait_drain();
    check("eop_clears_frame_active", 32'(frame_active), 32'd0);

    // Single-pixel frames covering the remaining modes.
    send(px(20, 30, 100), 1'b1, 1'b1, 3'd2, 8'd30, px(0, 0, 70), 1'b0);
    send(px(0, 128, 255), 1'b1, 1'b1, 3'd3, 8'd0, px(255, 127, 0), 1'b0);
    send(px(127, 128, 129), 1'b1, 1'b1, 3'd4, 8'd128, px(0, 255, 255), 1'b0);
    send(px(1, 2, 3), 1'b1, 1'b1, 3'd5, 8'd99, px(1, 2, 3), 1'b0);
    wait_drain();

    // Frame A (brighten 20) then frame B (invert, then a duplicate SOP to darken 10).
    send(px(1, 2, 3), 1'b1, 1'b0, 3'd1, 8'd20, px(21, 22, 23), 1'b0);
    send(px(100, 240, 250), 1'b0, 1'b0, 3'd3, 8'd0, px(120, 255, 255), 1'b0);
    send(px(5, 6, 7), 1'b0, 1'b1, 3'd3, 8'd0, px(25, 26, 27), 1'b0);
    send(px(5, 6, 7), 1'b1, 1'b0, 3'd3, 8'd0, px(250, 249, 248), 1'b0);
    send(px(0, 0, 0), 1'b0, 1'b0, 3'd1, 8'd5, px(255, 255, 255), 1'b0);
    send(px(50, 5, 10), 1'b1, 1'b0, 3'd2, 8'd10, px(40, 0, 0), 1'b0);
    send(px(255, 255, 255), 1'b0, 1'b1, 3'd1, 8'd1, px(245, 245, 245), 1'b0);
    wait_drain();

    // 16-beat frame: random gaps first, then a 5-cycle output stall under full input.
    for (int i = 0; i < 8; i++)
      send(px(i * 16, 255 - i * 3, i * 9), 1'(i == 0), 1'b0, 3'd1, 8'd7,
           {sat_add(i * 9, 7), sat_add(255 - i * 3, 7), sat_add(i * 16, 7)}, 1'b1);
    fork
      begin
        for (int i = 8; i < 16; i++)
          send(px(i * 16, 255 - i * 3, i * 9), 1'b0, 1'(i == 15), 3'd0, 8'd0,
               {sat_add(i * 9, 7), sat_add(255 - i * 3, 7), sat_add(i * 16, 7)}, 1'b0);
      end
      begin
        repeat (3) @(negedge clk);
        out_ready = 1'b0;
        acc = 0;
        low_ok = 1'b1;
        for (int k = 0; k < 5; k++) begin
          #2;
          if (in_valid && in_ready) acc++;
          if (k >= 2 && in_ready) low_ok = 1'b0;
          @(negedge clk);
        end
        out_ready = 1'b1;
        check("stall_accepts_le_2", 32'(acc <= 2), 32'd1);
        check("stall_in_ready_low", 32'(low_ok), 32'd1);
      end
    join
    wait_drain();

    // Reset with two beats in flight.
    @(negedge clk);
    out_ready = 1'b0;
    send(px(10, 20, 30), 1'b1, 1'b0, 3'd1, 8'd50, px(60, 70, 80), 1'b0);
    send(px(40, 50, 60), 1'b0, 1'b0, 3'd1, 8'd50, px(90, 100, 110), 1'b0);
    check("inflight_frame_active", 32'(frame_active), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_frame_active", 32'(frame_active), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    send(px(10, 20, 30), 1'b0, 1'b1, 3'd1, 8'd50, px(10, 20, 30), 1'b0);
    wait_drain();
    check("post_rst_frame_active", 32'(frame_active), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
